reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard_pkg.sv | 11 +
 rtl/reg_scoreboard.sv | 96 +++++++++
 tb/tb_reg_scoreboard.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions for the register scoreboard: register address
// width, register count and outstanding long-op limit.
package reg_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned NUM_REGS    = 32;
  localparam int unsigned MAX_PENDING = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks registers with an outstanding long-latency write
// and stalls decode on RAW, WAW or when the outstanding-write limit is reached.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS    = reg_scoreboard_pkg::NUM_REGS,
  parameter int unsigned MAX_PENDING = reg_scoreboard_pkg::MAX_PENDING
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               id_valid,
  input  logic [4:0]                         id_rs1_addr,
  input  logic                               id_rs1_used,
  input  logic [4:0]                         id_rs2_addr,
  input  logic                               id_rs2_used,
  input  logic [4:0]                         id_rd_addr,
  input  logic                               id_rd_write,
  input  logic                               id_long_op,
  input  logic                               id_flush,
  input  logic                               wb_long_valid,
  input  logic [4:0]                         wb_long_addr,
  output logic                               id_stall,
  output logic [NUM_REGS-1:0]                busy_vec,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
  output logic                               wb_err
);

  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  logic [NUM_REGS-1:0] busy_next;
  logic [CNT_W-1:0]    cnt_next;
  logic                err_next;
  logic                any_clr;
  logic                issue;
  logic                dec_live;
  logic                raw_hit;
  logic                waw_hit;
  logic                cap_hit;
  logic                rd_nz;
  logic                wb_nz;

  // A register being written back this cycle counts as ready; forwarding
  // supplies the value, so it must not stall decode.
  function automatic logic eff_busy(input logic [NUM_REGS-1:0] b,
                                    input reg_addr_t r,
                                    input logic wv,
                                    input reg_addr_t wa);
    return b[r] & ~(wv & (wa == r) & (r != '0));
  endfunction

  always_comb begin
    busy_next = busy_vec;
    cnt_next  = pending_cnt;
    err_next  = wb_err;

    rd_nz    = (id_rd_addr != '0);
    wb_nz    = (wb_long_addr != '0);
    dec_live = id_valid & ~id_flush;
    any_clr  = wb_long_valid & wb_nz & busy_vec[wb_long_addr];

    raw_hit = (id_rs1_used & eff_busy(busy_vec, id_rs1_addr, wb_long_valid, wb_long_addr))
            | (id_rs2_used & eff_busy(busy_vec, id_rs2_addr, wb_long_valid, wb_long_addr));
    waw_hit = id_rd_write & rd_nz & eff_busy(busy_vec, id_rd_addr, wb_long_valid, wb_long_addr);
    cap_hit = id_long_op & id_rd_write & rd_nz & (pending_cnt == CNT_MAX) & ~any_clr;

    id_stall = dec_live & (raw_hit | waw_hit | cap_hit);
    issue    = dec_live & ~id_stall & id_rd_write & id_long_op & rd_nz;

    // Clear before set so a same-register collision leaves the bit set.
    if (any_clr) busy_next[wb_long_addr] = 1'b0;
    if (issue)   busy_next[id_rd_addr]   = 1'b1;
    busy_next[0] = 1'b0;

    if (issue && !any_clr && pending_cnt != CNT_MAX)
      cnt_next = pending_cnt + CNT_W'(1);
    else if (any_clr && !issue && pending_cnt != '0)
      cnt_next = pending_cnt - CNT_W'(1);

    if (wb_long_valid && wb_nz && !busy_vec[wb_long_addr])
      err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec    <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      busy_vec    <= busy_next;
      pending_cnt <= cnt_next;
      wb_err      <= err_next;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic        id_rs1_used;
  logic [4:0]  id_rs2_addr;
  logic        id_rs2_used;
  logic [4:0]  id_rd_addr;
  logic        id_rd_write;
  logic        id_long_op;
  logic        id_flush;
  logic        wb_long_valid;
  logic [4:0]  wb_long_addr;
  logic        id_stall;
  logic [31:0] busy_vec;
  logic [2:0]  pending_cnt;
  logic        wb_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  reg_scoreboard #(.NUM_REGS(32), .MAX_PENDING(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_write(id_rd_write), .id_long_op(id_long_op),
    .id_flush(id_flush), .wb_long_valid(wb_long_valid), .wb_long_addr(wb_long_addr),
    .id_stall(id_stall), .busy_vec(busy_vec), .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_addr = 0; id_rs1_used = 0; id_rs2_addr = 0; id_rs2_used = 0;
    id_rd_addr = 0; id_rd_write = 0; id_long_op = 0; id_flush = 0;
    wb_long_valid = 0; wb_long_addr = 0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic rs1u, input logic [4:0] rs2,
                     input logic rs2u, input logic [4:0] rd, input logic rdw,
                     input logic lng, input logic fl);
    id_valid = 1; id_rs1_addr = rs1; id_rs1_used = rs1u; id_rs2_addr = rs2;
    id_rs2_used = rs2u; id_rd_addr = rd; id_rd_write = rdw; id_long_op = lng; id_flush = fl;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_long_valid = 1; wb_long_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational outputs are settled #1 after the inputs change.
  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    settle();
    check("reset_busy", busy_vec, 32'h0);
    check("reset_cnt", {29'd0, pending_cnt}, 32'd0);
    check("reset_err", {31'd0, wb_err}, 32'd0);
    check("reset_stall", {31'd0, id_stall}, 32'd0);

    // Load to x5, then a dependent read of x5
    dec(0, 0, 0, 0, 5, 1, 1, 0); settle();
    check("issue5_stall", {31'd0, id_stall}, 32'd0);
    tick(); idle();
    check("issue5_busy", busy_vec, 32'h0000_0020);
    check("issue5_cnt", {29'd0, pending_cnt}, 32'd1);
    dec(5, 1, 0, 0, 6, 1, 0, 0); settle();
    check("raw5_stall_a", {31'd0, id_stall}, 32'd1);
    tick();
    check("raw5_stall_b", {31'd0, id_stall}, 32'd1);
    id_valid = 0; settle();
    check("novalid_stall", {31'd0, id_stall}, 32'd0);
    id_valid = 1; wb(5); settle();
    check("raw5_wb_release", {31'd0, id_stall}, 32'd0);
    tick(); idle();
    check("wb5_busy", busy_vec, 32'h0);
    check("wb5_cnt", {29'd0, pending_cnt}, 32'd0);
    check("wb5_err", {31'd0, wb_err}, 32'd0);

    // WAW on x7, then the same instruction flushed
    dec(0, 0, 0, 0, 7, 1, 1, 0); tick(); idle();
    check("issue7_busy", busy_vec, 32'h0000_0080);
    dec(0, 0, 0, 0, 7, 1, 1, 0); settle();
    check("waw7_stall", {31'd0, id_stall}, 32'd1);
    id_flush = 1; settle();
    check("waw7_flush_stall", {31'd0, id_stall}, 32'd0);
    tick(); idle();
    check("flush_busy", busy_vec, 32'h0000_0080);
    check("flush_cnt", {29'd0, pending_cnt}, 32'd1);
    wb(7); tick(); idle();
    check("wb7_busy", busy_vec, 32'h0);
    check("wb7_cnt", {29'd0, pending_cnt}, 32'd0);

    // Fill to capacity with x1..x4
    for (int i = 1; i <= 4; i++) begin
      dec(0, 0, 0, 0, 5'(i), 1, 1, 0); tick();
    end
    idle();
    check("cap_busy", busy_vec, 32'h0000_001E);
    check("cap_cnt", {29'd0, pending_cnt}, 32'd4);
    dec(0, 0, 0, 0, 9, 1, 1, 0); settle();
    check("cap_stall", {31'd0, id_stall}, 32'd1);
    tick();
    check("cap_hold_cnt", {29'd0, pending_cnt}, 32'd4);
    check("cap_hold_busy", busy_vec, 32'h0000_001E);
    wb(1); settle();
    check("cap_wb_nostall", {31'd0, id_stall}, 32'd0);
    tick(); idle();
    check("cap_swap_cnt", {29'd0, pending_cnt}, 32'd4);
    check("cap_swap_busy", busy_vec, 32'h0000_021C);

    // rd=0 long op, rs1=0 read, rs2 RAW
    dec(0, 1, 0, 0, 0, 1, 1, 0); settle();
    check("rd0_stall", {31'd0, id_stall}, 32'd0);
    tick(); idle();
    check("rd0_busy", busy_vec, 32'h0000_021C);
    check("rd0_cnt", {29'd0, pending_cnt}, 32'd4);
    dec(0, 1, 9, 1, 0, 0, 0, 0); settle();
    check("rs2_raw_stall", {31'd0, id_stall}, 32'd1);
    idle();

    // Spurious write-back to idle x12
    wb(12); tick(); idle();
    check("spur_err", {31'd0, wb_err}, 32'd1);
    check("spur_cnt", {29'd0, pending_cnt}, 32'd4);
    check("spur_busy", busy_vec, 32'h0000_021C);
    tick();
    check("spur_err_sticky", {31'd0, wb_err}, 32'd1);

    // Reset with outstanding ops (x3 busy)
    rst = 1; tick(); rst = 0; settle();
    check("rst_busy", busy_vec, 32'h0);
    check("rst_cnt", {29'd0, pending_cnt}, 32'd0);
    check("rst_err", {31'd0, wb_err}, 32'd0);
    dec(3, 1, 8, 1, 0, 0, 0, 0); settle();
    check("rst_read3_stall", {31'd0, id_stall}, 32'd0);
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
